// File: rtl/skeeball_hole_sensor.sv
// Skeeball lane front-end: synchronizes and debounces the seven hole switches, priority-encodes hits,
// emits one-cycle hit pulses and the ballclk strobe, and counts balls per game.
// Optional SKEEBALL_STUCK_DETECT_EN bounds LOCKOUT time and raises a sticky sensor_fault.
module skeeball_hole_sensor #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned LOCKOUT_CYCLES  = 64,
  parameter int unsigned BALLS_PER_GAME  = 9,
  parameter int unsigned STUCK_CYCLES    = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [6:0] raw_hole,
  output logic       in100,
  output logic       in50,
  output logic       in40,
  output logic       in30,
  output logic       in20,
  output logic       in10,
  output logic       in0,
  output logic       ballclk,
  output logic       playstate,
  output logic [3:0] balls_left,
  output logic       sensor_fault
);

  localparam int unsigned CNT_MAX = (DEBOUNCE_CYCLES > LOCKOUT_CYCLES) ? DEBOUNCE_CYCLES : LOCKOUT_CYCLES;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {IDLE, ARMED, QUALIFY, PULSE, STROBE, LOCKOUT} state_t;

  state_t        state, state_nx;
  logic [6:0]    sync1, sync;
  logic [2:0]    pcode, cap, cap_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [3:0]    balls, balls_nx;

`ifdef SKEEBALL_STUCK_DETECT_EN
  localparam int unsigned SW = $clog2(STUCK_CYCLES + 1);
  logic [SW-1:0] stuck_cnt, stuck_nx;
  logic          fault, fault_nx;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync  <= '0;
    end else begin
      sync1 <= raw_hole;
      sync  <= sync1;
    end
  end

  // Hole code: index of the highest set bit plus one, 0 meaning no hole.
  always_comb begin
    pcode = '0;
    for (int unsigned i = 0; i < 7; i++)
      if (sync[i]) pcode = 3'(i + 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      cap   <= '0;
      balls <= '0;
`ifdef SKEEBALL_STUCK_DETECT_EN
      stuck_cnt <= '0;
      fault     <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      cap   <= cap_nx;
      balls <= balls_nx;
`ifdef SKEEBALL_STUCK_DETECT_EN
      stuck_cnt <= stuck_nx;
      fault     <= fault_nx;
`endif
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    cap_nx   = cap;
    balls_nx = balls;
`ifdef SKEEBALL_STUCK_DETECT_EN
    stuck_nx = stuck_cnt;
    fault_nx = fault;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = ARMED;
          balls_nx = 4'(BALLS_PER_GAME);
`ifdef SKEEBALL_STUCK_DETECT_EN
          fault_nx = 1'b0;
`endif
        end
      end
      ARMED: begin
        if (pcode != '0) begin
          state_nx = QUALIFY;
          cnt_nx   = CW'(1);
          cap_nx   = pcode;
        end
      end
      QUALIFY: begin
        // The hit fires one sample after the counter has already reached the limit.
        if (pcode == '0) begin
          state_nx = ARMED;
        end else if (pcode != cap) begin
          cap_nx = pcode;
          cnt_nx = CW'(1);
        end else if (cnt == CW'(DEBOUNCE_CYCLES)) begin
          state_nx = PULSE;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      PULSE: begin
        state_nx = STROBE;
        cnt_nx   = '0;
      end
      STROBE: begin
        if (cnt == CW'(1)) begin
          balls_nx = balls - 4'd1;
          state_nx = (balls == 4'd1) ? IDLE : LOCKOUT;
          cnt_nx   = '0;
`ifdef SKEEBALL_STUCK_DETECT_EN
          stuck_nx = '0;
`endif
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      LOCKOUT: begin
        if (sync != '0)
          cnt_nx = '0;
        else if (cnt == CW'(LOCKOUT_CYCLES))
          state_nx = ARMED;
        else
          cnt_nx = cnt + CW'(1);
`ifdef SKEEBALL_STUCK_DETECT_EN
        // A normal all-clear exit takes precedence over the stuck timeout.
        if (state_nx == LOCKOUT) begin
          if (stuck_cnt == SW'(STUCK_CYCLES - 1)) begin
            state_nx = ARMED;
            fault_nx = 1'b1;
          end else begin
            stuck_nx = stuck_cnt + SW'(1);
          end
        end
`endif
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in100 = (state == PULSE) && (cap == 3'd7);
    in50  = (state == PULSE) && (cap == 3'd6);
    in40  = (state == PULSE) && (cap == 3'd5);
    in30  = (state == PULSE) && (cap == 3'd4);
    in20  = (state == PULSE) && (cap == 3'd3);
    in10  = (state == PULSE) && (cap == 3'd2);
    in0   = (state == PULSE) && (cap == 3'd1);
  end

  assign ballclk    = (state == STROBE);
  assign playstate  = (state != IDLE);
  assign balls_left = balls;

`ifdef SKEEBALL_STUCK_DETECT_EN
  assign sensor_fault = fault;
`else
  assign sensor_fault = 1'b0;
`endif

endmodule

// File: tb/tb_skeeball_hole_sensor.sv
// Bench for skeeball_hole_sensor: directed and randomized switch stimulus checked every cycle against
// a history-based reference model (runs of hole codes, edge-indexed ball events).
`timescale 1ns/1ps
module tb_skeeball_hole_sensor;
  localparam int unsigned D = 4;
  localparam int unsigned L = 8;
  localparam int unsigned B = 9;
  localparam int unsigned S = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [6:0] raw_hole = '0;
  logic       in100, in50, in40, in30, in20, in10, in0;
  logic       ballclk, playstate, sensor_fault;
  logic [3:0] balls_left;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  skeeball_hole_sensor #(
    .DEBOUNCE_CYCLES(D),
    .LOCKOUT_CYCLES (L),
    .BALLS_PER_GAME (B),
    .STUCK_CYCLES   (S)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .raw_hole(raw_hole),
    .in100(in100), .in50(in50), .in40(in40), .in30(in30), .in20(in20), .in10(in10), .in0(in0),
    .ballclk(ballclk), .playstate(playstate), .balls_left(balls_left), .sensor_fault(sensor_fault)
  );

  function automatic logic [13:0] obs_vec();
    return {in100, in50, in40, in30, in20, in10, in0, ballclk, playstate, balls_left, sensor_fault};
  endfunction

  // Reference model: hole code seen by the lane at edge k is prio(raw sampled at edge k-2).
  int         k = 0;
  int         arm_from = -1, hit_e = -1, lock_from = -1, mballs = 0;
  logic [2:0] hist [256];
  logic [2:0] hit_code = '0;
  logic [6:0] m1 = '0, m2 = '0;
  bit         game = 1'b0, mfault = 1'b0;
  logic [6:0] exp_holes;
  logic [13:0] exp_vec = '0;

  function automatic logic [2:0] prio(input logic [6:0] v);
    logic [2:0] p = '0;
    for (int i = 0; i < 7; i++) if (v[i]) p = 3'(i + 1);
    return p;
  endfunction

  function automatic bit same_run(input int at, input int n);
    for (int j = 1; j < n; j++)
      if (hist[(at - j) % 256] !== hist[at % 256]) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m1 = '0; m2 = '0; game = 1'b0; mballs = 0; mfault = 1'b0;
      arm_from = -1; hit_e = -1; lock_from = -1; hit_code = '0;
      for (int i = 0; i < 256; i++) hist[i] = '0;
    end else begin
      k++;
      hist[k % 256] = prio(m2);
      m2 = m1;
      m1 = raw_hole;
      if (!game) begin
        if (start) begin
          game = 1'b1; mballs = B; arm_from = k + 1; mfault = 1'b0;
        end
      end else if (arm_from >= 0) begin
        if (hist[k % 256] != 3'd0 && k - int'(D) >= arm_from && same_run(k, D + 1)) begin
          hit_e = k; hit_code = hist[k % 256]; arm_from = -1;
        end
      end else if (hit_e >= 0 && k == hit_e + 3) begin
        mballs--;
        if (mballs == 0) game = 1'b0;
        else lock_from = k + 1;
      end else if (lock_from >= 0) begin
        if (hist[k % 256] == 3'd0 && k - int'(L) >= lock_from && same_run(k, L + 1)) begin
          arm_from = k + 1; lock_from = -1;
        end
`ifdef SKEEBALL_STUCK_DETECT_EN
        else if (k == lock_from + int'(S) - 1) begin
          arm_from = k + 1; lock_from = -1; mfault = 1'b1;
        end
`endif
      end
    end
    exp_holes = (hit_e >= 0 && k == hit_e) ? (7'd1 << (hit_code - 3'd1)) : 7'd0;
    exp_vec = {exp_holes, (hit_e >= 0 && (k == hit_e + 1 || k == hit_e + 2)), game, 4'(mballs), mfault};
  end

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; raw_hole = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic start_game();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; raw_hole = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (obs_vec() !== 14'd0) begin n_bad++; $display("FAIL reset_values got=%b want=%b", obs_vec(), 14'd0); end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (obs_vec() !== exp_vec) begin n_bad++; $display("FAIL reset_release got=%b want=%b", obs_vec(), exp_vec); end
  endtask

  task automatic test_single_ball();
    int first = -1, pulses = 0;
    do_reset(); start_game();
    raw_hole = 7'b0000100;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs_vec() !== exp_vec) begin n_bad++; $display("FAIL single_ball cyc%0d got=%b want=%b", i, obs_vec(), exp_vec); end
      if (in20) begin pulses++; if (first < 0) first = i; end
      if (i == 20) raw_hole = '0;
    end
    n_cmp++;
    if (first != int'(D) + 3) begin n_bad++; $display("FAIL hit_latency got=%0d want=%0d", first, D + 3); end
    n_cmp++;
    if (pulses != 1) begin n_bad++; $display("FAIL single_pulse_count got=%0d want=1", pulses); end
    n_cmp++;
    if (balls_left !== 4'd8) begin n_bad++; $display("FAIL single_balls_left got=%0d want=8", balls_left); end
  endtask

  task automatic test_glitch_then_gutter();
    int pulses = 0, first0 = -1;
    do_reset(); start_game();
    raw_hole = 7'b1000000;
    for (int i = 1; i <= 45; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs_vec() !== exp_vec) begin n_bad++; $display("FAIL glitch cyc%0d got=%b want=%b", i, obs_vec(), exp_vec); end
      if (i < 20 && obs_vec() >> 7 != 14'd0) pulses++;
      if (in0 && first0 < 0) first0 = i;
      if (i == 3) raw_hole = '0;
      if (i == 19) begin
        n_cmp++;
        if (pulses != 0 || balls_left !== 4'd9) begin
          n_bad++; $display("FAIL glitch_ignored got=%0d/%0d want=0/9", pulses, balls_left);
        end
      end
      if (i == 20) raw_hole = 7'b0000001;
      if (i == 30) raw_hole = '0;
    end
    n_cmp++;
    if (first0 != 20 + int'(D) + 3) begin n_bad++; $display("FAIL gutter_pulse got=%0d want=%0d", first0, 23 + D); end
  endtask

  task automatic test_simultaneous();
    int p50 = 0, pother = 0;
    do_reset(); start_game();
    raw_hole = 7'b0110000;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs_vec() !== exp_vec) begin n_bad++; $display("FAIL simultaneous cyc%0d got=%b want=%b", i, obs_vec(), exp_vec); end
      if (in50) p50++;
      if (in100 | in40 | in30 | in20 | in10 | in0) pother++;
      if (i == 12) raw_hole = '0;
    end
    n_cmp++;
    if (p50 != 1 || pother != 0) begin n_bad++; $display("FAIL simultaneous_only50 got=%0d/%0d want=1/0", p50, pother); end
  endtask

  task automatic test_lockout();
    int p30 = 0, p50 = 0, p20 = 0;
    do_reset(); start_game();
    raw_hole = 7'b0001000;
    for (int i = 1; i <= 90; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs_vec() !== exp_vec) begin n_bad++; $display("FAIL lockout cyc%0d got=%b want=%b", i, obs_vec(), exp_vec); end
      p30 += int'(in30); p50 += int'(in50); p20 += int'(in20);
      case (i)
        8, 17, 60: raw_hole = '0;
        11:        raw_hole = 7'b0100000;
        50:        raw_hole = 7'b0000100;
        default: ;
      endcase
    end
    n_cmp++;
    if (p30 != 1 || p50 != 0 || p20 != 1) begin
      n_bad++; $display("FAIL lockout_pulses got=%0d/%0d/%0d want=1/0/1", p30, p50, p20);
    end
  endtask

  task automatic test_full_game();
    int pulses = 0, falls = 0;
    logic prev_bc = 1'b0, prev_play = 1'b0;
    do_reset(); start_game();
    for (int b = 0; b < 10; b++) begin
      raw_hole = 7'd1 << $urandom_range(0, 6);
      for (int i = 1; i <= 32; i++) begin
        @(negedge clk);
        n_cmp++;
        if (obs_vec() !== exp_vec) begin n_bad++; $display("FAIL full_game b%0d cyc%0d got=%b want=%b", b, i, obs_vec(), exp_vec); end
        if (obs_vec() >> 7 != 14'd0) pulses++;
        if (prev_bc && !ballclk) begin
          falls++;
          if (falls == 9) begin
            n_cmp++;
            if (!(prev_play && !playstate && balls_left == 4'd0)) begin
              n_bad++; $display("FAIL game_over got=%b%b/%0d want=10/0", prev_play, playstate, balls_left);
            end
          end
        end
        prev_bc = ballclk; prev_play = playstate;
        if (i == 8) raw_hole = '0;
      end
    end
    n_cmp++;
    if (pulses != 9 || playstate !== 1'b0) begin n_bad++; $display("FAIL full_game_pulses got=%0d/%b want=9/0", pulses, playstate); end
  endtask

  task automatic test_random();
    int rem = 0;
    do_reset();
    for (int i = 1; i <= 800; i++) begin
      if (rem == 0) begin
        raw_hole = ($urandom_range(0, 9) < 4) ? 7'd0 : 7'($urandom_range(1, 127));
        rem = (raw_hole == 7'd0) ? $urandom_range(1, 15) : $urandom_range(1, 12);
      end
      rem--;
      start = ($urandom_range(0, 19) == 0);
      @(negedge clk);
      n_cmp++;
      if (obs_vec() !== exp_vec) begin n_bad++; $display("FAIL random cyc%0d got=%b want=%b", i, obs_vec(), exp_vec); end
    end
    start = 1'b0; raw_hole = '0;
  endtask

  task automatic test_reset_midball();
    bit seen = 1'b0;
    do_reset(); start_game();
    raw_hole = 7'b0010000;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs_vec() !== exp_vec) begin n_bad++; $display("FAIL midball cyc%0d got=%b want=%b", i, obs_vec(), exp_vec); end
      if (ballclk) begin seen = 1'b1; break; end
    end
    n_cmp++;
    if (!seen) begin n_bad++; $display("FAIL midball_strobe got=0 want=1"); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (obs_vec() !== 14'd0) begin n_bad++; $display("FAIL midball_reset got=%b want=%b", obs_vec(), 14'd0); end
    raw_hole = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

`ifdef SKEEBALL_STUCK_DETECT_EN
  task automatic test_stuck();
    int p10 = 0;
    bit fault_seen = 1'b0;
    do_reset(); start_game();
    raw_hole = 7'b0000010;
    for (int i = 1; i <= 90; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs_vec() !== exp_vec) begin n_bad++; $display("FAIL stuck cyc%0d got=%b want=%b", i, obs_vec(), exp_vec); end
      p10 += int'(in10);
      if (sensor_fault) fault_seen = 1'b1;
    end
    n_cmp++;
    if (!fault_seen || p10 < 2) begin n_bad++; $display("FAIL stuck_fault got=%b/%0d want=1/>=2", fault_seen, p10); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (obs_vec() !== 14'd0) begin n_bad++; $display("FAIL stuck_reset got=%b want=%b", obs_vec(), 14'd0); end
    raw_hole = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask
`endif

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single_ball();
    test_glitch_then_gutter();
    test_simultaneous();
    test_lockout();
    test_full_game();
    test_random();
    test_reset_midball();
`ifdef SKEEBALL_STUCK_DETECT_EN
    test_stuck();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
